// File: rtl/ps2_rx_fifo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ps2_rx_fifo_if
// Brief    : Read-side bus between the PS/2 receive FIFO and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_rx_fifo_if #(
  parameter int ADDR_W = 3
);
  logic              rd;
  logic              clr_err;
  logic [7:0]        data_out;
  logic              ready;
  logic [ADDR_W:0]   count;
  logic              parity_err;
  logic              frame_err;
  logic              overflow;

  // master: the consumer (Wishbone slave); slave: the receive FIFO
  modport master (
    output rd, clr_err,
    input  data_out, ready, count, parity_err, frame_err, overflow
  );
  modport slave (
    input  rd, clr_err,
    output data_out, ready, count, parity_err, frame_err, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ps2_rx_fifo
// Brief    : PS/2 device-to-host receiver with pin filtering, frame/parity
//            checking and a first-word fall-through scan-code FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       PS2_clk,
  input  wire logic       PS2_Data,
  ps2_rx_fifo_if.slave    bus
);

  localparam int c_flt_w = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int c_tmo_w = $clog2(TIMEOUT_CYC);
  localparam logic [c_flt_w-1:0] c_flt_max = c_flt_w'(FILTER_LEN - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0]    c_depth   = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START_OK = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4
  } state_t;

  logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic               r_clk_f, r_fall;
  logic [c_flt_w-1:0] r_flt_cnt;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shreg;
  logic               r_par;
  logic [c_tmo_w-1:0] r_tcnt;
  logic               r_push;

  logic               w_shift, w_bit_clr, w_par_ld, w_push_req, w_set_pe, w_set_fe;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]    r_cnt;
  logic               r_pe, r_fe, r_ov;
  logic               w_do_pop, w_do_push, w_drop;

  // Filtered clock moves only once the synchronised pin has disagreed with it
  // for FILTER_LEN consecutive samples; fall is registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_clk_f   <= 1'b1;
      r_fall    <= 1'b0;
      r_flt_cnt <= '0;
    end else begin
      r_clk_s1 <= PS2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_Data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 != r_clk_f) begin
        if (r_flt_cnt == c_flt_max) begin
          r_clk_f   <= r_clk_s2;
          r_fall    <= r_clk_f;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + 1'b1;
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_bit_clr   = 1'b0;
    w_par_ld    = 1'b0;
    w_push_req  = 1'b0;
    w_set_pe    = 1'b0;
    w_set_fe    = 1'b0;
    if (r_state != S_IDLE && r_tcnt == c_tmo_max) begin
      w_state_nxt = S_IDLE;
      w_set_fe    = 1'b1;
    end else if (r_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt = S_START_OK;
            w_bit_clr   = 1'b1;
          end
        end
        S_START_OK, S_DATA: begin
          w_shift     = 1'b1;
          w_state_nxt = (r_bit_cnt == 3'd7) ? S_PARITY : S_DATA;
        end
        S_PARITY: begin
          w_par_ld    = 1'b1;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (!r_dat_s2)               w_set_fe   = 1'b1;
          else if (^r_shreg ^ r_par)   w_push_req = 1'b1;
          else                         w_set_pe   = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_tcnt    <= '0;
      r_push    <= 1'b0;
    end else begin
      if (w_bit_clr)    r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift)  r_shreg <= {r_dat_s2, r_shreg[7:1]};
      if (w_par_ld) r_par   <= r_dat_s2;
      if (w_state_nxt == S_IDLE || r_fall) r_tcnt <= '0;
      else                                 r_tcnt <= r_tcnt + 1'b1;
      r_push <= w_push_req;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_do_pop  = bus.rd && (r_cnt != '0);
  assign w_do_push = r_push && ((r_cnt != c_depth) || w_do_pop);
  assign w_drop    = r_push && !w_do_push;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_pe     <= 1'b0;
      r_fe     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_set_pe)         r_pe <= 1'b1;
      else if (bus.clr_err) r_pe <= 1'b0;
      if (w_set_fe)         r_fe <= 1'b1;
      else if (bus.clr_err) r_fe <= 1'b0;
      if (w_drop)           r_ov <= 1'b1;
      else if (bus.clr_err) r_ov <= 1'b0;
    end
  end

  assign bus.ready      = (r_cnt != '0);
  assign bus.data_out   = (r_cnt != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.count      = r_cnt;
  assign bus.parity_err = r_pe;
  assign bus.frame_err  = r_fe;
  assign bus.overflow   = r_ov;

endmodule
`default_nettype wire
